// File: rtl/ofifo.sv
// Output FIFO: one circular FIFO per array column, popped together as a row.
// Optional macro OFIFO_RELU_EN clamps negative head values to zero on out.
module ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     ready,
    output logic                     overflow
);

    localparam int aw = $clog2(depth);

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] accept;
    logic           pop;

    // Flags decode only the pointer registers, never this cycle's wr/rd.
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign ready   = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar k = 0; k < col; k++) begin : g_col
        logic [aw:0]          wptr;
        logic [aw:0]          rptr;
        logic [psum_bw-1:0]   mem [depth];
        logic [psum_bw-1:0]   head;
        logic [psum_bw-1:0]   head_q;

        assign empty[k] = (wptr == rptr);
        assign full[k]  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
        // A full column still takes the write when the same edge frees its head slot.
        assign accept[k] = wr[k] & (~full[k] | pop);

        // NOTE: storage has no reset branch; stale contents are hidden because
        // out is masked by o_valid, and omitting the reset keeps this a plain RAM.
        always_ff @(posedge clk) begin
            if (accept[k]) begin
                mem[wptr[aw-1:0]] <= in[k*psum_bw +: psum_bw];
            end
        end

        // NOTE: state registers use non-blocking assignments so every column
        // samples the same pre-edge pop/accept values.
        always_ff @(posedge clk) begin
            if (reset) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (accept[k]) wptr <= wptr + 1'b1;
                if (pop)       rptr <= rptr + 1'b1;
            end
        end

        assign head = mem[rptr[aw-1:0]];

`ifdef OFIFO_RELU_EN
        assign head_q = head[psum_bw-1] ? '0 : head;
`else
        assign head_q = head;
`endif

        assign out[k*psum_bw +: psum_bw] = o_valid ? head_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (|(wr & full & ~{col{pop}})) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
REQ-001 The block SHALL expose parameter col, default 8, number of array columns collected.
REQ-002 The block SHALL expose parameter psum_bw, default 16, partial-sum width per column.
REQ-003 The block SHALL expose parameter depth, default 64, entries per column FIFO; power of two, at least 2.
REQ-004 Port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in, input, col*psum_bw bits: psums from the array south edge; column k occupies bits [k*psum_bw +: psum_bw].
REQ-007 Port wr, input, col bits: per-column write strobe, one per array column valid.
REQ-008 Port rd, input, 1 bit: pops one entry from every column simultaneously.
REQ-009 Port out, output, col*psum_bw bits: head row, using the same column packing as in.
REQ-010 Port o_valid, output, 1 bit: every column FIFO is non-empty.
REQ-011 Port o_full, output, 1 bit: at least one column FIFO is full.
REQ-012 Port ready, output, 1 bit: no column FIFO is full; equals ~o_full.
REQ-013 Port overflow, output, 1 bit: sticky flag, a write was dropped.

Function
REQ-014 Each column SHALL be an independent circular FIFO of depth entries, with read and write pointers of log2(depth)+1 bits.
REQ-015 Full/empty SHALL be decided on the pointers: empty when they are equal; full when the MSBs differ and the remaining bits are equal.
REQ-016 Pointers SHALL wrap modulo 2*depth, and the index (pointer LSBs) SHALL wrap from depth-1 to 0 with no gap.
REQ-017 wr[k] high with column k not full SHALL store in[k] at the write index and advance the write pointer by one.
REQ-018 wr[k] high with column k full SHALL be accepted only if a pop of column k occurs in the same cycle; otherwise the data SHALL be dropped and overflow SHALL be set.
REQ-019 rd high with o_valid high SHALL advance every column's read pointer by one.
REQ-020 rd high with o_valid low SHALL be ignored, with no pointer change and no error flag.
REQ-021 out SHALL be first-word-fall-through: column k drives the entry at its read index combinationally.
REQ-022 out SHALL be forced to all-zero whenever o_valid is low.
REQ-023 Latency: a write at edge N SHALL be visible in o_valid/out after edge N, i.e. in cycle N+1, if all other columns are non-empty.
REQ-024 A simultaneous write and pop on the same column SHALL leave its occupancy unchanged, whether the column is empty-but-one, mid-level or full.
REQ-025 o_valid, o_full and ready SHALL be combinational decodes of the pointer registers only, never of this cycle's wr/rd.
REQ-026 overflow SHALL remain 1 once set, until reset.
REQ-027 Columns SHALL be allowed to skew: any column may lead by up to depth entries without affecting data order.

Reset
REQ-028 reset high at an edge SHALL clear all pointers and overflow, and SHALL override wr/rd in that same cycle.
REQ-029 After reset: o_valid=0, out=0, o_full=0, ready=1, overflow=0.
REQ-030 Storage array contents SHALL NOT be reset; they are unobservable because out is masked by o_valid.
REQ-031 Reset mid-operation SHALL discard all stored entries; the next entry read SHALL be the first one written after reset.

Configuration
REQ-032 With OFIFO_RELU_EN defined, out SHALL drive each column's head value clamped to zero when its MSB is 1, i.e. negative values, and SHALL pass non-negative values unchanged.
REQ-033 With OFIFO_RELU_EN undefined, out SHALL drive the stored two's-complement value unchanged.
REQ-034 The macro SHALL affect only the out datapath; flags, timing and storage SHALL be identical with or without it.

Verification
REQ-035 Reset, then wr=all-ones for 1 cycle with column k holding k+1 -> next cycle o_valid=1, out column k = k+1; pulse rd -> o_valid=0, out=0.
REQ-036 Skewed write, col=8: column 0 written at cycle 0, column 7 at cycle 7, staggered -> o_valid low until cycle 8, then the row reads back in order.
REQ-037 Fill column 3 to depth 64 while other columns stay empty -> o_full=1, ready=0; a 65th write to column 3 -> overflow=1 and the stored data is unchanged.
REQ-038 All columns full, wr=all-ones with rd=1 -> no overflow, occupancy stays 64, the popped row is the oldest one; run 200 cycles to exercise pointer wraparound with the data sequence intact.
REQ-039 Write 5 rows, assert reset during a rd -> o_valid=0 and overflow=0; the next row written is the next row read.
REQ-040 With OFIFO_RELU_EN, write -5 (16'hFFFB) and +9 -> read 0 and 9; without the macro -> read 16'hFFFB and 9.
